// File: rtl/memoredf_pkg.sv
// Shared types and sizing helpers for the MemorEDF queue dispatcher.
package memoredf_pkg;

  function automatic int queue_id_width(input int number_of_queues);
    return (number_of_queues > 1) ? $clog2(number_of_queues) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/transaction_fifo.sv
// Single-clock circular FIFO; head is visible combinationally at pop_data.
// Push is ignored when full and pop is ignored when empty; there is no pop-through when full.
module transaction_fifo #(
  parameter int QUEUE_DEPTH = 8,
  parameter int DATA_WIDTH  = 32,
  localparam int PW = $clog2(QUEUE_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(QUEUE_DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset: the pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_dispatcher.sv
// Per-queue transaction buffers that execute scheduler grants: pop granted queue, issue downstream
// with valid/ready (latency 1 from grant), report served/dropped; grant_ready falls while output is stalled.
module queue_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int QUEUE_DEPTH      = 8,
  parameter int DATA_WIDTH       = 32,
  localparam int IDW = queue_id_width(NUMBER_OF_QUEUES)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUMBER_OF_QUEUES-1:0]          in_valid,
  input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] in_data,
  output logic [NUMBER_OF_QUEUES-1:0]          in_ready,
  output logic [NUMBER_OF_QUEUES-1:0]          empty,
  input  logic                                 grant_valid,
  input  logic [IDW-1:0]                       grant_selection,
  output logic                                 grant_ready,
  output logic                                 grant_dropped,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [IDW-1:0]                       out_id,
  input  logic                                 out_ready,
  output logic                                 served,
  output logic [IDW-1:0]                       served_id
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  dispatch_state_t             state;
  dispatch_state_t             state_next;
  logic [DATA_WIDTH-1:0]       head  [NUMBER_OF_QUEUES];
  logic [CW-1:0]               count [NUMBER_OF_QUEUES];
  logic [NUMBER_OF_QUEUES-1:0] full;
  logic [NUMBER_OF_QUEUES-1:0] push;
  logic [NUMBER_OF_QUEUES-1:0] pop;
  logic                        grant_accept;
  logic                        grant_hit;
  logic                        handshake;

  assign grant_accept = grant_valid & grant_ready;
  // empty is the registered pre-edge view, so a same-cycle push cannot rescue a grant.
  assign grant_hit    = grant_accept & ~empty[grant_selection];
  assign handshake    = out_valid & out_ready;

  for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_queue
    assign push[q]     = in_valid[q] & ~full[q];
    assign pop[q]      = grant_hit & (grant_selection == IDW'(q));
    assign in_ready[q] = (count[q] < CW'(QUEUE_DEPTH));

    transaction_fifo #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[q]),
      .pop       (pop[q]),
      .push_data (in_data[q*DATA_WIDTH +: DATA_WIDTH]),
      .pop_data  (head[q]),
      .count     (count[q]),
      .empty     (empty[q]),
      .full      (full[q])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (grant_hit) begin
      state_next = ISSUE;
    end else if ((state == ISSUE) && !out_ready) begin
      state_next = ISSUE;
    end
  end

  // Accepting while the current output completes gives back-to-back issue.
  always_comb begin
    out_valid   = (state == ISSUE);
    grant_ready = (state == IDLE) | out_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data      <= '0;
      out_id        <= '0;
      served        <= 1'b0;
      served_id     <= '0;
      grant_dropped <= 1'b0;
    end else begin
      served        <= handshake;
      grant_dropped <= grant_accept & empty[grant_selection];
      if (handshake) begin
        served_id <= out_id;
      end
      if (grant_hit) begin
        out_data <= head[grant_selection];
        out_id   <= grant_selection;
      end
    end
  end

endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed bench for queue_dispatcher with hand-computed expectations.
module tb_queue_dispatcher;

  localparam int NQ  = 4;
  localparam int QD  = 8;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NQ-1:0]     in_valid;
  logic [NQ*DW-1:0]  in_data;
  logic [NQ-1:0]     in_ready;
  logic [NQ-1:0]     empty;
  logic              grant_valid;
  logic [IDW-1:0]    grant_selection;
  logic              grant_ready;
  logic              grant_dropped;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic              served;
  logic [IDW-1:0]    served_id;

  int n_cmp = 0;
  int n_err = 0;

  queue_dispatcher #(
    .NUMBER_OF_QUEUES (NQ),
    .QUEUE_DEPTH      (QD),
    .DATA_WIDTH       (DW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .empty           (empty),
    .grant_valid     (grant_valid),
    .grant_selection (grant_selection),
    .grant_ready     (grant_ready),
    .grant_dropped   (grant_dropped),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_id          (out_id),
    .out_ready       (out_ready),
    .served          (served),
    .served_id       (served_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    in_valid        = '0;
    in_data         = '0;
    grant_valid     = 1'b0;
    grant_selection = '0;
    out_ready       = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_empty", empty, 4'b1111);
    chk("rst_in_ready", in_ready, 4'b1111);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_served", served, 0);
    chk("rst_dropped", grant_dropped, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant_ready", grant_ready, 1);

    // Single transaction through queue 2
    in_valid = 4'b0100;
    in_data[2*DW +: DW] = 32'hA5A5_0001;
    tick();
    in_valid = '0;
    chk("single_empty_after_push", empty, 4'b1011);
    grant_valid = 1'b1;
    grant_selection = 2'd2;
    tick();
    grant_valid = 1'b0;
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 32'hA5A5_0001);
    chk("single_out_id", out_id, 2);
    chk("single_empty_after_pop", empty, 4'b1111);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_served", served, 1);
    chk("single_served_id", served_id, 2);
    chk("single_out_valid_drop", out_valid, 0);
    tick();
    chk("single_served_once", served, 0);

    // Fill queue 0, then an ignored ninth push
    for (int i = 0; i < QD; i++) begin
      in_valid = 4'b0001;
      in_data[0 +: DW] = i;
      tick();
    end
    chk("full_in_ready", in_ready, 4'b1110);
    in_data[0 +: DW] = 32'h0000_0099;
    tick();
    in_valid = '0;
    chk("full_in_ready_hold", in_ready, 4'b1110);
    chk("full_not_empty", empty, 4'b1110);
    out_ready = 1'b1;
    grant_valid = 1'b1;
    grant_selection = 2'd0;
    for (int i = 0; i < QD; i++) begin
      tick();
      chk($sformatf("drain_data_%0d", i), out_data, i);
      chk($sformatf("drain_valid_%0d", i), out_valid, 1);
    end
    grant_valid = 1'b0;
    chk("drain_empty", empty, 4'b1111);
    tick();
    out_ready = 1'b0;
    chk("drain_last_served", served, 1);
    chk("drain_idle", out_valid, 0);

    // Backpressure then back-to-back
    in_valid = 4'b1010;
    in_data[1*DW +: DW] = 32'h1111_0001;
    in_data[3*DW +: DW] = 32'h3333_0003;
    tick();
    in_valid = '0;
    grant_valid = 1'b1;
    grant_selection = 2'd1;
    tick();
    grant_selection = 2'd3;
    chk("bp_out_id", out_id, 1);
    chk("bp_out_data", out_data, 32'h1111_0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_grant_ready_%0d", i), grant_ready, 0);
      chk($sformatf("bp_data_stable_%0d", i), out_data, 32'h1111_0001);
      chk($sformatf("bp_q3_held_%0d", i), empty, 4'b0111);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_grant_ready", grant_ready, 1);
    tick();
    grant_valid = 1'b0;
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_out_id", out_id, 3);
    chk("b2b_out_data", out_data, 32'h3333_0003);
    chk("b2b_served", served, 1);
    chk("b2b_served_id", served_id, 1);
    tick();
    out_ready = 1'b0;
    chk("b2b_served_id_2", served_id, 3);
    chk("b2b_idle", out_valid, 0);

    // Grant to an empty queue
    grant_valid = 1'b1;
    grant_selection = 2'd0;
    tick();
    grant_valid = 1'b0;
    chk("drop_pulse", grant_dropped, 1);
    chk("drop_no_valid", out_valid, 0);
    chk("drop_empty", empty, 4'b1111);
    chk("drop_in_ready", in_ready, 4'b1111);
    tick();
    chk("drop_pulse_once", grant_dropped, 0);

    // Push and grant the same empty queue in one cycle
    in_valid = 4'b0010;
    in_data[1*DW +: DW] = 32'h7777_0007;
    grant_valid = 1'b1;
    grant_selection = 2'd1;
    tick();
    in_valid = '0;
    grant_valid = 1'b0;
    chk("race_dropped", grant_dropped, 1);
    chk("race_no_valid", out_valid, 0);
    chk("race_entry_kept", empty, 4'b1101);
    grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0;
    chk("race_out_valid", out_valid, 1);
    chk("race_out_data", out_data, 32'h7777_0007);
    chk("race_out_id", out_id, 1);
    chk("race_no_drop", grant_dropped, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("race_served", served, 1);
    chk("race_served_id", served_id, 1);

    // Asynchronous reset while an output is pending
    in_valid = 4'b1100;
    in_data[2*DW +: DW] = 32'hBEEF_0002;
    in_data[3*DW +: DW] = 32'hCAFE_0003;
    tick();
    in_valid = '0;
    grant_valid = 1'b1;
    grant_selection = 2'd2;
    tick();
    grant_valid = 1'b0;
    chk("arst_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_empty", empty, 4'b1111);
    chk("arst_in_ready", in_ready, 4'b1111);
    chk("arst_served", served, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_id", out_id, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    chk("arst_stays_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
